// File: rtl/pipe_pkg.sv
// Encodings and widths shared by the pipeline stages.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC4 = 2'b10,
        WD_RSV = 2'b11
    } wd_sel_e;

    typedef enum logic [2:0] {
        DM_LW  = 3'b000,
        DM_LH  = 3'b001,
        DM_LHU = 3'b010,
        DM_LB  = 3'b011,
        DM_LBU = 3'b100
    } dmtype_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load extractor: picks the byte/halfword out of an aligned word and extends it.
module load_ext
    import pipe_pkg::*;
(
    input  logic [2:0]      i_dmtype,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_result
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    // Undefined load types fall back to a full-word load.
    always_comb begin
        case (i_dmtype)
            DM_LH:   o_result = {{16{w_half[15]}}, w_half};
            DM_LHU:  o_result = {16'd0, w_half};
            DM_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            DM_LBU:  o_result = {24'd0, w_byte};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux and retirement counter.
// Macro WB_INSTRET_EN builds the 64-bit instret counter; otherwise instret is tied to 0.
module mem_wb_stage
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_rf_wr,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wd_sel,
    input  logic [2:0]      in_dmtype,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_mem_data,
    input  logic [XLEN-1:0] in_pc,
    output logic            RFWr,
    output logic [4:0]      WrDtAdr,
    output logic [XLEN-1:0] WrDt,
    output logic            fwd_valid,
    output logic [63:0]     instret
);

    logic            r_valid;
    logic            r_rf_wr;
    logic [4:0]      r_rd;
    logic [1:0]      r_wd_sel;
    logic [2:0]      r_dmtype;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_alu_res;
    logic [XLEN-1:0] r_mem_data;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_load_val;

    // Flush only kills the valid bit; the payload is irrelevant once invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_rf_wr    <= 1'b0;
            r_rd       <= '0;
            r_wd_sel   <= '0;
            r_dmtype   <= '0;
            r_addr_lo  <= '0;
            r_alu_res  <= '0;
            r_mem_data <= '0;
            r_pc       <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_rf_wr    <= in_rf_wr;
            r_rd       <= in_rd;
            r_wd_sel   <= in_wd_sel;
            r_dmtype   <= in_dmtype;
            r_addr_lo  <= in_addr_lo;
            r_alu_res  <= in_alu_res;
            r_mem_data <= in_mem_data;
            r_pc       <= in_pc;
        end
    end

    load_ext u_load_ext (
        .i_dmtype  (r_dmtype),
        .i_addr_lo (r_addr_lo),
        .i_word    (r_mem_data),
        .o_result  (w_load_val)
    );

    // Outputs depend on registered state only, so they are steady across the whole cycle.
    always_comb begin
        case (r_wd_sel)
            WD_ALU:  WrDt = r_alu_res;
            WD_MEM:  WrDt = w_load_val;
            WD_PC4:  WrDt = r_pc + 32'd4;
            default: WrDt = '0;
        endcase
    end

    assign RFWr      = r_valid & r_rf_wr & (r_rd != 5'd0) & (r_wd_sel != WD_RSV);
    assign WrDtAdr   = r_rd;
    assign fwd_valid = RFWr;

`ifdef WB_INSTRET_EN
    logic        w_retire;
    logic [63:0] r_instret;

    // The held entry retires when it leaves the stage, even if a flush lands on the same edge.
    assign w_retire = r_valid & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed checks of mem_wb_stage against a behavioural write-back model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_rf_wr;
    logic [4:0]  in_rd;
    logic [1:0]  in_wd_sel, in_addr_lo;
    logic [2:0]  in_dmtype;
    logic [31:0] in_alu_res, in_mem_data, in_pc;
    logic        RFWr, fwd_valid;
    logic [4:0]  WrDtAdr;
    logic [31:0] WrDt;
    logic [63:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the entry currently sitting in write-back.
    bit        m_valid, m_rf_wr;
    bit [4:0]  m_rd;
    bit [1:0]  m_wd_sel, m_lo;
    bit [2:0]  m_dm;
    bit [31:0] m_alu, m_mem, m_pc;
    bit [63:0] m_retired;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rf_wr(in_rf_wr), .in_rd(in_rd),
        .in_wd_sel(in_wd_sel), .in_dmtype(in_dmtype), .in_addr_lo(in_addr_lo),
        .in_alu_res(in_alu_res), .in_mem_data(in_mem_data), .in_pc(in_pc),
        .RFWr(RFWr), .WrDtAdr(WrDtAdr), .WrDt(WrDt), .fwd_valid(fwd_valid),
        .instret(instret)
    );

    function automatic bit [31:0] ref_load(bit [2:0] dm, bit [1:0] lo, bit [31:0] word);
        longint unsigned w = word;
        longint unsigned v;
        case (dm)
            3'd1, 3'd2: begin
                v = (w / (lo >= 2 ? 65536 : 1)) % 65536;
                if (dm == 3'd1 && v >= 32768) v = v + 64'hFFFF0000;
            end
            3'd3, 3'd4: begin
                v = (w / (longint'(1) << (8 * lo))) % 256;
                if (dm == 3'd3 && v >= 128) v = v + 64'hFFFFFF00;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    function automatic bit exp_rfwr();
        return m_valid && m_rf_wr && (m_rd != 0) && (m_wd_sel != 2'd3);
    endfunction

    function automatic bit [31:0] exp_wrdt();
        bit [31:0] pc4;
        pc4 = m_pc + 32'd4;
        case (m_wd_sel)
            2'd0:    return m_alu;
            2'd1:    return ref_load(m_dm, m_lo, m_mem);
            2'd2:    return pc4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [63:0] exp_instret();
`ifdef WB_INSTRET_EN
        return m_retired;
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rf_wr = 0; m_rd = 0; m_wd_sel = 0; m_lo = 0; m_dm = 0;
        m_alu = 0; m_mem = 0; m_pc = 0; m_retired = 0;
    endtask

    task automatic drive(bit v, bit wr, bit [4:0] rd, bit [1:0] sel, bit [2:0] dm,
                         bit [1:0] lo, bit [31:0] alu, bit [31:0] mem, bit [31:0] pc);
        in_valid = v; in_rf_wr = wr; in_rd = rd; in_wd_sel = sel; in_dmtype = dm;
        in_addr_lo = lo; in_alu_res = alu; in_mem_data = mem; in_pc = pc;
    endtask

    // One rising edge; the model follows the retire/flush/stall rules, then outputs settle.
    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            if (m_valid && !stall) m_retired = m_retired + 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid; m_rf_wr = in_rf_wr; m_rd = in_rd; m_wd_sel = in_wd_sel;
                m_dm = in_dmtype; m_lo = in_addr_lo; m_alu = in_alu_res;
                m_mem = in_mem_data; m_pc = in_pc;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 0; stall = 0; flush = 0;
        drive(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hCAFE0001, 32'h0, 32'h0);
        model_clear();
        repeat (3) cycle();
        n_tests++;
        if (RFWr !== 1'b0 || fwd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rfwr got RFWr=%b fwd=%b exp 0", RFWr, fwd_valid);
        end
        n_tests++;
        if (WrDtAdr !== 5'd0 || WrDt !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got adr=%0d wd=%h exp 0/0", WrDtAdr, WrDt);
        end
        n_tests++;
        if (instret !== 64'd0) begin
            n_fail++; $display("FAIL reset_instret got %0d exp 0", instret);
        end
        rst = 1;
        drive(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h00001234, 32'h0, 32'h0);
        cycle();
        n_tests++;
        if (RFWr !== 1'b1 || WrDtAdr !== 5'd7 || WrDt !== 32'h00001234) begin
            n_fail++; $display("FAIL first_capture got rfwr=%b adr=%0d wd=%h exp 1/7/00001234", RFWr, WrDtAdr, WrDt);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_load_ext();
        bit [2:0]  dms [3] = '{3'd3, 3'd4, 3'd1};
        bit [1:0]  los [3] = '{2'd0, 2'd0, 2'd2};
        bit [31:0] wds [3] = '{32'h12345680, 32'h12345680, 32'h80017FFF};
        bit [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd3, 2'd1, dms[i], los[i], 32'h0, wds[i], 32'h0);
            cycle();
            n_tests++;
            if (WrDt !== exps[i] || RFWr !== 1'b1) begin
                n_fail++; $display("FAIL load_ext[%0d] got wd=%h rfwr=%b exp %h/1", i, WrDt, RFWr, exps[i]);
            end
            $display("[TB] load_ext dm=%0d lo=%0d word=%h wd=%h", dms[i], los[i], wds[i], WrDt);
        end
    endtask

    task automatic test_x0();
        drive(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        cycle();
        n_tests++;
        if (RFWr !== 1'b0 || fwd_valid !== 1'b0) begin
            n_fail++; $display("FAIL x0_rfwr got %b/%b exp 0", RFWr, fwd_valid);
        end
        drive(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        cycle();
        n_tests++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL x0_instret got %0d exp %0d", instret, exp_instret());
        end
        $display("[TB] x0 write: rfwr=%b instret=%0d", RFWr, instret);
    endtask

    task automatic test_stall_flush();
        bit [63:0] base;
        drive(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h00000011, 32'h0, 32'h0);
        cycle();
        base = exp_instret();
        drive(0, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h00000099, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (RFWr !== 1'b1 || WrDtAdr !== 5'd5 || WrDt !== 32'h11 || instret !== base) begin
                n_fail++; $display("FAIL stall_hold[%0d] got rfwr=%b adr=%0d wd=%h ir=%0d exp 1/5/11/%0d", i, RFWr, WrDtAdr, WrDt, instret, base);
            end
            if (i < 3) begin
                stall = 1;
                cycle();
            end
        end
        flush = 1; stall = 1;
        cycle();
        n_tests++;
        if (RFWr !== 1'b0 || instret !== exp_instret()) begin
            n_fail++; $display("FAIL stall_flush got rfwr=%b ir=%0d exp 0/%0d", RFWr, instret, exp_instret());
        end
        flush = 0; stall = 0;
        $display("[TB] stall+flush: rfwr=%b instret=%0d", RFWr, instret);
    endtask

    task automatic test_pc4_wrap();
        bit [31:0] pcs [2] = '{32'hFFFFFFFC, 32'h00000100};
        bit [31:0] exps[2] = '{32'h00000000, 32'h00000104};
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, pcs[i]);
            cycle();
            n_tests++;
            if (WrDt !== exps[i] || RFWr !== 1'b1) begin
                n_fail++; $display("FAIL pc4[%0d] got wd=%h rfwr=%b exp %h/1", i, WrDt, RFWr, exps[i]);
            end
            $display("[TB] pc4 pc=%h wd=%h", pcs[i], WrDt);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
            cycle();
            n_tests++;
            if (RFWr !== exp_rfwr() || fwd_valid !== exp_rfwr()) begin
                n_fail++; bad++;
                $display("FAIL rand_rfwr c=%0d got %b/%b exp %b", c, RFWr, fwd_valid, exp_rfwr());
            end
            if (m_valid) begin
                n_tests++;
                if (WrDtAdr !== m_rd || WrDt !== exp_wrdt()) begin
                    n_fail++; bad++;
                    $display("FAIL rand_data c=%0d got adr=%0d wd=%h exp %0d/%h", c, WrDtAdr, WrDt, m_rd, exp_wrdt());
                end
            end
            n_tests++;
            if (instret !== exp_instret()) begin
                n_fail++; bad++;
                $display("FAIL rand_instret c=%0d got %0d exp %0d", c, instret, exp_instret());
            end
            $display("[TB] rand c=%0d st=%b fl=%b rfwr=%b adr=%0d wd=%h ir=%0d", c, stall, flush, RFWr, WrDtAdr, WrDt, instret);
        end
        stall = 0; flush = 0;
        $display("[TB] random: %0d bad comparisons", bad);
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h5A5A5A5A, 32'h0, 32'h0);
        cycle();
        n_tests++;
        if (RFWr !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre got rfwr=%b exp 1", RFWr);
        end
        #2 rst = 0;
        model_clear();
        #1;
        n_tests++;
        if (RFWr !== 1'b0 || fwd_valid !== 1'b0 || WrDt !== 32'd0 || instret !== 64'd0) begin
            n_fail++; $display("FAIL mid_async got rfwr=%b fwd=%b wd=%h ir=%0d exp 0", RFWr, fwd_valid, WrDt, instret);
        end
        cycle();
        #2 rst = 1;
        drive(0, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h5A5A5A5A, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (RFWr !== 1'b0 || instret !== 64'd0) begin
                n_fail++; $display("FAIL mid_idle[%0d] got rfwr=%b ir=%0d exp 0/0", i, RFWr, instret);
            end
        end
        drive(1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h00000042, 32'h0, 32'h0);
        cycle();
        drive(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        cycle();
        n_tests++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL mid_after got ir=%0d exp %0d", instret, exp_instret());
        end
        $display("[TB] reset mid-op: instret=%0d", instret);
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_x0();
        test_stall_flush();
        test_pc4_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
